bin_to_dec_seg7: RTL

//  Sequential successor to the combinational hex-to-decimal display path.

---
 rtl/bin_to_dec_seg7.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bin_to_dec_seg7.sv
// -----------------------------------------------------------------------------
// bin_to_dec_seg7
//   Iterative binary-to-decimal converter driving DIGITS active-low 7-segment
//   displays. A request is accepted on an edge where i_valid && o_ready; the
//   value is converted with a double-dabble (shift / add-3) engine, one input
//   bit per clock, then formatted (sign, leading-zero blanking, overflow) and
//   registered onto the outputs together with a one-cycle o_done pulse.
//
//   Ports
//     i_clk       clock, all state changes on the rising edge
//     i_reset     synchronous, active-high reset
//     i_valid     conversion request
//     o_ready     engine idle; request accepted when i_valid && o_ready
//     i_value     binary value, sampled at acceptance
//     i_signed    1: i_value is two's complement (sampled at acceptance)
//     i_blank_lz  1: blank leading zeros (sampled at acceptance)
//     o_done      one-cycle pulse, all outputs below update in the same cycle
//     o_seg       active-low segments {g..a}, digit k at [7k+6:7k], k=0 units
//     o_bcd       magnitude in BCD (low DIGITS digits), digit k at [4k+3:4k]
//     o_neg       displayed value is negative
//     o_overflow  magnitude (plus sign) does not fit in DIGITS displays
//
//   Latency: acceptance edge -> o_done edge is WIDTH+1 edges.
// -----------------------------------------------------------------------------
module bin_to_dec_seg7 #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_signed,
  input  logic                  i_blank_lz,
  output logic                  o_done,
  output logic [DIGITS*7-1:0]   o_seg,
  output logic [DIGITS*4-1:0]   o_bcd,
  output logic                  o_neg,
  output logic                  o_overflow
);

  // Decimal digits of 2^w-1 equal those of 2^w (a power of two is never a
  // power of ten), i.e. floor(w*log10(2))+1.
  function automatic int bcd_digits(input int w);
    return int'((longint'(w) * 30103) / 100000) + 1;
  endfunction

  localparam int BCD_N = bcd_digits(WIDTH);
  // Formatting works on a zero-padded copy wide enough for both the
  // accumulator and the display count.
  localparam int MAXD  = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FORMAT
  } state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [WIDTH-1:0]      bin_q,     bin_d;
  logic [BCD_N*4-1:0]    bcd_q,     bcd_d;
  logic                  sign_q,    sign_d;    // request is negative
  logic                  blank_q,   blank_d;   // request wants blanking
  logic [DIGITS*7-1:0]   seg_q,     seg_d;
  logic [DIGITS*4-1:0]   bcd_out_q, bcd_out_d;
  logic                  neg_q,     neg_d;
  logic                  ovf_q,     ovf_d;
  logic                  done_q,    done_d;

  // ---------------------------------------------------------------------------
  // Double-dabble correction: every nibble >= 5 gets +3 before the shift so
  // that the shift carries correctly into the next decimal digit.
  // ---------------------------------------------------------------------------
  logic [BCD_N*4-1:0] bcd_adj;

  // NOTE: every variable written in an always_comb gets a default first so no
  // path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_N; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // ---------------------------------------------------------------------------
  // Display formatting from the finished BCD accumulator.
  // ---------------------------------------------------------------------------
  logic [MAXD*4-1:0]   bcd_ext;
  logic [DIGITS*7-1:0] fmt_seg;
  logic                fmt_ovf;
  int                  fmt_n;     // number of significant digits (>=1)

  always_comb begin
    bcd_ext                = '0;
    bcd_ext[BCD_N*4-1:0]   = bcd_q;

    fmt_n = 1;
    for (int k = 0; k < MAXD; k++) begin
      if (bcd_ext[4*k +: 4] != 4'd0) fmt_n = k + 1;
    end

    // The minus sign occupies one display of its own.
    fmt_ovf = sign_q ? (fmt_n > DIGITS - 1) : (fmt_n > DIGITS);

    fmt_seg = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (fmt_ovf) begin
        fmt_seg[7*k +: 7] = SEG_MINUS;
      end else if (!blank_q) begin
        // Unblanked: sign replaces the most significant display.
        if (sign_q && k == DIGITS - 1) fmt_seg[7*k +: 7] = SEG_MINUS;
        else                           fmt_seg[7*k +: 7] = seg_code(bcd_ext[4*k +: 4]);
      end else begin
        // Blanked: sign sits directly left of the top significant digit.
        // fmt_n >= 1 keeps digit 0 always visible.
        if (k < fmt_n)                 fmt_seg[7*k +: 7] = seg_code(bcd_ext[4*k +: 4]);
        else if (sign_q && k == fmt_n) fmt_seg[7*k +: 7] = SEG_MINUS;
        else                           fmt_seg[7*k +: 7] = SEG_BLANK;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    blank_d   = blank_q;
    seg_d     = seg_q;
    bcd_out_d = bcd_out_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          sign_d  = i_signed & i_value[WIDTH-1];
          blank_d = i_blank_lz;
          // WIDTH-bit negate: the most negative value yields 2^(WIDTH-1),
          // which is the correct unsigned magnitude.
          bin_d   = (i_signed & i_value[WIDTH-1]) ? (~i_value + WIDTH'(1)) : i_value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = S_FORMAT;
      end

      S_FORMAT: begin
        seg_d     = fmt_seg;
        bcd_out_d = bcd_ext[DIGITS*4-1:0];
        neg_d     = sign_q;
        ovf_d     = fmt_ovf;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      blank_q   <= 1'b0;
      seg_q     <= '1;
      bcd_out_q <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
      blank_q   <= blank_d;
      seg_q     <= seg_d;
      bcd_out_q <= bcd_out_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign o_done     = done_q;
  assign o_seg      = seg_q;
  assign o_bcd      = bcd_out_q;
  assign o_neg      = neg_q;
  assign o_overflow = ovf_q;

endmodule
